// File: rtl/cache_defs.sv
// Shared definitions for the L1I-to-L2 request path: trace/L2 command codes,
// line-address width, FSM encoding and the queued request record.
package cache_defs;

  localparam int ADDR_W = 26;

  typedef enum logic [3:0] {
    TR_INST_FETCH = 4'd2,
    TR_INVALIDATE = 4'd3,
    TR_RESET      = 4'd8,
    TR_PRINT      = 4'd9
  } trace_cmd_e;

  typedef enum logic [1:0] {
    L2_NOP      = 2'b00,
    L2_READ_OUT = 2'b01
  } l2_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Request storage ring with occupancy tracking and a comparator against the
// most recently written entry, used upstream to coalesce duplicate misses.
module req_fifo
  import cache_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           wr_en_i,
  input  req_t           wr_data_i,
  input  logic           rd_en_i,
  output req_t           rd_data_o,
  output logic           tail_match_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [PTR_W:0] count_o
);

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] tail_ptr;

  assign tail_ptr     = wr_ptr_q - PTR_W'(1);
  assign rd_data_o    = mem_q[rd_ptr_q];
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o      = count_q;
  // Tail is only meaningful while something is still queued.
  assign tail_match_o = !empty_o && (mem_q[tail_ptr] == wr_data_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/l2_req_queue.sv
// L1I miss-request queue: coalesces back-to-back duplicates, buffers line
// fills and issues them to L2 over valid/ready, with statistics counters.
module l2_req_queue
  import cache_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [1:0]        cmd_in,
  input  logic [ADDR_W-1:0] add_in,
  output logic              req_valid,
  output logic [1:0]        req_cmd,
  output logic [ADDR_W-1:0] req_add,
  input  logic              req_ready,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic [31:0]       enq_cnt,
  output logic [31:0]       merge_cnt,
  output logic [31:0]       drop_cnt,
  output logic [31:0]       iss_cnt
);

  state_e            state_q, state_d;
  req_t              push_req, head_req;
  logic              push, tail_match;
  logic              do_merge, do_enq, do_drop, do_pop;
  logic              load, hs;
  logic              req_valid_q;
  logic [1:0]        req_cmd_q;
  logic [ADDR_W-1:0] req_add_q;
  logic [31:0]       enq_q, merge_q, drop_q, iss_q;

  assign push     = (cmd_in != L2_NOP);
  assign push_req = '{cmd: cmd_in, addr: add_in};

  // Fullness is judged on the pre-pop count, so a same-edge pop never rescues a push.
  assign do_merge = push && tail_match;
  assign do_enq   = push && !tail_match && !full && !clear;
  assign do_drop  = push && !tail_match && full;
  assign do_pop   = load && !clear;

  req_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .wr_en_i      (do_enq),
    .wr_data_i    (push_req),
    .rd_en_i      (do_pop),
    .rd_data_o    (head_req),
    .tail_match_o (tail_match),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          hs = 1'b1;
          if (count != '0) load = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_cmd_q   <= L2_NOP;
      req_add_q   <= '0;
    end else if (clear) begin
      req_valid_q <= 1'b0;
      req_cmd_q   <= L2_NOP;
      req_add_q   <= '0;
    end else if (load) begin
      req_valid_q <= 1'b1;
      req_cmd_q   <= head_req.cmd;
      req_add_q   <= head_req.addr;
    end else if (hs) begin
      req_valid_q <= 1'b0;
      req_cmd_q   <= L2_NOP;
      req_add_q   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_q   <= '0;
      merge_q <= '0;
      drop_q  <= '0;
      iss_q   <= '0;
    end else if (clear) begin
      enq_q   <= '0;
      merge_q <= '0;
      drop_q  <= '0;
      iss_q   <= '0;
    end else begin
      if (do_enq)   enq_q   <= enq_q + 32'd1;
      if (do_merge) merge_q <= merge_q + 32'd1;
      if (do_drop)  drop_q  <= drop_q + 32'd1;
      if (hs)       iss_q   <= iss_q + 32'd1;
    end
  end

  assign req_valid = req_valid_q;
  assign req_cmd   = req_cmd_q;
  assign req_add   = req_add_q;
  assign enq_cnt   = enq_q;
  assign merge_cnt = merge_q;
  assign drop_cnt  = drop_q;
  assign iss_cnt   = iss_q;

endmodule

// File: tb/tb_l2_req_queue.sv
// Directed bench for l2_req_queue: hand-computed expectations for issue
// latency, coalescing, overflow, back-to-back issue, clear and async reset.
module tb_l2_req_queue;

  logic        clk = 1'b0;
  logic        rst, clear, req_ready;
  logic [1:0]  cmd_in;
  logic [25:0] add_in;
  logic        req_valid, full, empty;
  logic [1:0]  req_cmd;
  logic [25:0] req_add;
  logic [3:0]  count;
  logic [31:0] enq_cnt, merge_cnt, drop_cnt, iss_cnt;

  int n_chk = 0;
  int n_err = 0;

  l2_req_queue dut (
    .clk(clk), .rst(rst), .clear(clear), .cmd_in(cmd_in), .add_in(add_in),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_add(req_add),
    .req_ready(req_ready), .full(full), .empty(empty), .count(count),
    .enq_cnt(enq_cnt), .merge_cnt(merge_cnt), .drop_cnt(drop_cnt),
    .iss_cnt(iss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [25:0] a);
    cmd_in = 2'b01;
    add_in = a;
    tick();
    cmd_in = 2'b00;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] seq [3];
    rst = 1'b1; clear = 1'b0; req_ready = 1'b0; cmd_in = 2'b00; add_in = '0;
    #12;
    chk("rst_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_cmd",   {30'd0, req_cmd}, 32'd0);
    rst = 1'b0;
    tick();

    // single push, ready held high: valid for exactly one cycle
    req_ready = 1'b1;
    push(26'h0000123);
    chk("s_cnt1",  {28'd0, count}, 32'd1);
    chk("s_val0",  {31'd0, req_valid}, 32'd0);
    tick();
    chk("s_val1",  {31'd0, req_valid}, 32'd1);
    chk("s_add",   {6'd0, req_add}, 32'h0000123);
    chk("s_cmd",   {30'd0, req_cmd}, 32'd1);
    tick();
    chk("s_val2",  {31'd0, req_valid}, 32'd0);
    chk("s_iss",   iss_cnt, 32'd1);
    chk("s_enq",   enq_cnt, 32'd1);
    tick();
    chk("s_idle",  {31'd0, req_valid}, 32'd0);

    // coalescing: A A B B A
    req_ready = 1'b0;
    do_clear();
    push(26'h00000AA); push(26'h00000AA);
    push(26'h00000BB); push(26'h00000BB);
    push(26'h00000AA);
    chk("m_merge", merge_cnt, 32'd2);
    chk("m_enq",   enq_cnt, 32'd3);
    chk("m_count", {28'd0, count}, 32'd2);
    seq[0] = 26'h00000AA; seq[1] = 26'h00000BB; seq[2] = 26'h00000AA;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("m_ord%0d", i), {6'd0, req_add}, {6'd0, seq[i]});
      chk($sformatf("m_v%0d", i), {31'd0, req_valid}, 32'd1);
      req_ready = 1'b1;
      tick();
    end
    chk("m_done", {31'd0, req_valid}, 32'd0);
    chk("m_iss",  iss_cnt, 32'd3);

    // overflow, then drain back-to-back
    req_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 10; i++) push(26'h100 + 26'(i));
    chk("o_count", {28'd0, count}, 32'd8);
    chk("o_full",  {31'd0, full}, 32'd1);
    chk("o_drop",  drop_cnt, 32'd1);
    chk("o_enq",   enq_cnt, 32'd9);
    chk("o_head",  {6'd0, req_add}, 32'h100);
    req_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tick();
      chk($sformatf("o_v%0d", i), {31'd0, req_valid}, 32'd1);
      chk($sformatf("o_a%0d", i), {6'd0, req_add}, 32'h100 + i);
    end
    tick();
    chk("o_end",  {31'd0, req_valid}, 32'd0);
    chk("o_iss",  iss_cnt, 32'd9);
    chk("o_empty", {31'd0, empty}, 32'd1);

    // full queue: push + handshake on the same edge
    req_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 9; i++) push(26'h200 + 26'(i));
    chk("f_full", {31'd0, full}, 32'd1);
    req_ready = 1'b1;
    push(26'h3FF);
    req_ready = 1'b0;
    chk("f_drop",  drop_cnt, 32'd1);
    chk("f_count", {28'd0, count}, 32'd7);
    chk("f_iss",   iss_cnt, 32'd1);
    chk("f_add",   {6'd0, req_add}, 32'h201);

    // clear wins over push and handshake in ISSUE
    clear = 1'b1; req_ready = 1'b1; cmd_in = 2'b01; add_in = 26'h3AB;
    tick();
    clear = 1'b0; req_ready = 1'b0; cmd_in = 2'b00;
    chk("c_valid", {31'd0, req_valid}, 32'd0);
    chk("c_count", {28'd0, count}, 32'd0);
    chk("c_empty", {31'd0, empty}, 32'd1);
    chk("c_iss",   iss_cnt, 32'd0);
    chk("c_enq",   enq_cnt, 32'd0);
    chk("c_drop",  drop_cnt, 32'd0);
    tick();
    chk("c_stay",  {31'd0, req_valid}, 32'd0);

    // async reset mid-ISSUE with three queued
    for (int i = 0; i < 4; i++) push(26'h400 + 26'(i));
    push(26'h403);
    chk("r_pre_cnt", {28'd0, count}, 32'd3);
    chk("r_pre_val", {31'd0, req_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("r_valid", {31'd0, req_valid}, 32'd0);
    chk("r_count", {28'd0, count}, 32'd0);
    chk("r_empty", {31'd0, empty}, 32'd1);
    chk("r_enq",   enq_cnt, 32'd0);
    chk("r_merge", merge_cnt, 32'd0);
    chk("r_drop",  drop_cnt, 32'd0);
    chk("r_iss",   iss_cnt, 32'd0);
    #2 rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/l2_req_queue.md
Name: l2_req_queue

Overview:
- Sits directly downstream of the L1 instruction cache, between its miss-request outputs (26-bit line address, 2-bit command) and the next-level (L2) cache port.
- Buffers line-fill requests in a small FIFO and coalesces back-to-back duplicates.
- Issues requests to L2 over a valid/ready handshake and keeps counters for the statistics module.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two).
- PTR_W, 3, log2(DEPTH).
- ADDR_W, 26, line-address width (address bits [31:6]).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush, pulsed on trace command 8 (RESET).
- cmd_in  input  2  request command from the cache; 2'b00 = no request, 2'b01 = READ.
- add_in  input  ADDR_W  line address from the cache; sampled only when cmd_in != 0.
- req_valid  output  1  request to L2 is valid.
- req_cmd  output  2  command to L2.
- req_add  output  ADDR_W  line address to L2.
- req_ready  input  1  L2 accepts the request.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  PTR_W+1  number of queued entries, excluding the one in flight.
- enq_cnt  output  32  accepted pushes.
- merge_cnt  output  32  coalesced pushes.
- drop_cnt  output  32  pushes rejected because the queue was full.
- iss_cnt  output  32  completed L2 handshakes.

Behaviour:
Reset values (on rst, asynchronous):
- FSM state IDLE; pointers 0; count 0; empty 1; full 0.
- req_valid 0; req_cmd 2'b00; req_add 0.
- All four counters 0.

Clear:
- Same effect as rst, applied at posedge.
- Overrides any push, pop or handshake in that cycle.
- An in-flight request is abandoned: req_valid drops and iss_cnt is not incremented.

Push (cmd_in != 0), evaluated in this order:
- Merge: if the queue is not empty and {cmd_in, add_in} equals the tail entry (most recent write), the entry is not written; merge_cnt += 1.
- Accept: otherwise, if count < DEPTH, write at the write pointer; the pointer wraps modulo DEPTH; enq_cnt += 1.
- Drop: otherwise drop_cnt += 1. Fullness uses count before any same-cycle pop, so a push to a full queue is dropped even if a pop happens in the same cycle.
- Merge never compares against the in-flight output register.

FSM (2 states):
- IDLE: req_valid = 0. If count > 0, at the next posedge load the head into req_cmd/req_add, pop it (read pointer += 1, count -= 1), set req_valid = 1 and go to ISSUE.
- An entry pushed at edge N is therefore presented at edge N+1 at the earliest; minimum latency from push to req_valid is 1 cycle.
- ISSUE: req_valid, req_cmd and req_add are held stable until req_ready = 1 is sampled at a posedge; then iss_cnt += 1.
- After the handshake, if count > 0 at that edge, load and pop the next head in the same edge (back-to-back, no bubble) and stay in ISSUE; otherwise set req_valid = 0 and go to IDLE.
- req_ready is ignored while in IDLE.

Simultaneous push and pop in the same edge:
- count is unchanged.
- A push into an empty queue cannot be popped in that same edge.

Arithmetic:
- count ranges 0..DEPTH and never wraps.
- The 32-bit counters wrap silently.

Decomposition:
- Shared package cache_defs holds:
  - trace command codes: RESET 4'd8, INVALIDATE 4'd3, INST_FETCH 4'd2, PRINT 4'd9;
  - L2 command encodings: NOP 2'b00, READ_OUT 2'b01;
  - ADDR_W, and the FSM state encoding.
- One sub-module, req_fifo: storage array, pointers, count, full/empty and the tail-match comparator.
- The parent block holds the FSM, the output registers and the counters.

Test Plan:
- rst mid-ISSUE with 3 entries queued -> req_valid 0, count 0, empty 1, all counters 0 immediately, without waiting for a clock edge.
- Single push add_in=26'h0000123, req_ready tied 1 -> req_valid for exactly 1 cycle at edge N+1 with req_add 26'h0000123; then iss_cnt 1, enq_cnt 1, state IDLE.
- Pushes A, A, B, B, A on consecutive cycles with req_ready 0 -> merge_cnt 2, enq_cnt 3; request order out is A, B, A.
- req_ready 0, 10 distinct pushes -> first entry in flight, 8 queued, full 1, drop_cnt 1; then req_ready 1 -> 9 back-to-back issues with no bubble, iss_cnt 9.
- Full queue with push and handshake in the same edge -> push dropped (drop_cnt +1), count 7 afterwards.
- clear asserted together with a push and req_ready=1 in ISSUE -> everything zeroed; iss_cnt and enq_cnt stay 0.
